// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing from a 100 MHz clock.
// Produces the pixel counters, the display-valid flag, active-low syncs, a
// 2x-upscaled 320x240 ROM address, a frame strobe and a slow blink square wave.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_DISP       = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_DISP       = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic [16:0] pixel_addr,
  output logic        pix_tick,
  output logic        frame_tick,
  output logic        clk_blink
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FCNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST    = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [9:0]        H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]        V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]        H_VIS        = 10'(H_DISP);
  localparam logic [9:0]        V_VIS        = 10'(V_DISP);
  localparam logic [9:0]        H_SYNC_START = 10'(H_DISP + H_FP);
  localparam logic [9:0]        H_SYNC_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0]        V_SYNC_START = 10'(V_DISP + V_FP);
  localparam logic [9:0]        V_SYNC_END   = 10'(V_DISP + V_FP + V_SYNC);
  localparam logic [16:0]       ROW_STRIDE   = 17'(H_DISP / 2);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [9:0]        h_q, h_d;
  logic [9:0]        v_q, v_d;
  logic              valid_q, valid_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              pix_tick_q, pix_tick_d;
  logic              frame_tick_q, frame_tick_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              blink_q, blink_d;
  logic              adv;
  logic              h_wrap;
  logic              v_wrap;
  logic [16:0]       addr;

  // Next-state: clock divider, raster counters, and syncs/valid decoded from
  // the next counter values so they switch on the same edge as the counters.
  always_comb begin
    adv    = (div_q == DIV_LAST);
    h_wrap = adv && (h_q == H_LAST);
    v_wrap = h_wrap && (v_q == V_LAST);

    div_d = adv ? '0 : div_q + 1'b1;

    h_d = h_q;
    if (adv) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
    end

    v_d = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 10'd1;
    end

    valid_d = (h_d < H_VIS) && (v_d < V_VIS);
    hsync_d = !((h_d >= H_SYNC_START) && (h_d < H_SYNC_END));
    vsync_d = !((v_d >= V_SYNC_START) && (v_d < V_SYNC_END));

    pix_tick_d   = adv;
    frame_tick_d = v_wrap;

    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (v_wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset to the (0,0) raster position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      h_q          <= '0;
      v_q          <= '0;
      valid_q      <= 1'b1;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      pix_tick_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      fcnt_q       <= '0;
      blink_q      <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      v_q          <= v_d;
      valid_q      <= valid_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      pix_tick_q   <= pix_tick_d;
      frame_tick_q <= frame_tick_d;
      fcnt_q       <= fcnt_d;
      blink_q      <= blink_d;
    end
  end

  // ROM address for the 2x-upscaled image; forced to 0 outside the visible area.
  always_comb begin
    addr = '0;
    if (valid_q) begin
      addr = 17'(h_q >> 1) + ROW_STRIDE * 17'(v_q >> 1);
    end
  end

  assign h_cnt      = h_q;
  assign v_cnt      = v_q;
  assign valid      = valid_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign pixel_addr = addr;
  assign pix_tick   = pix_tick_q;
  assign frame_tick = frame_tick_q;
  assign clk_blink  = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size and reduced-parameter instances checked every
// clock against a closed-form raster model, plus targeted boundary checks.
module tb_vga_timing_gen;

  typedef logic [42:0] obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic rst_s_n = 1'b0;

  logic [9:0]  h_f, v_f, h_s, v_s;
  logic        valid_f, hs_f, vs_f, pt_f, ft_f, bl_f;
  logic        valid_s, hs_s, vs_s, pt_s, ft_s, bl_s;
  logic [16:0] addr_f, addr_s;

  vga_timing_gen dut_full (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_f), .v_cnt(v_f), .valid(valid_f),
    .hsync(hs_f), .vsync(vs_f), .pixel_addr(addr_f), .pix_tick(pt_f),
    .frame_tick(ft_f), .clk_blink(bl_f)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(6), .V_FP(1), .V_SYNC(1), .V_BP(1), .BLINK_FRAMES(2)
  ) dut_small (
    .clk(clk), .rst_n(rst_s_n), .h_cnt(h_s), .v_cnt(v_s), .valid(valid_s),
    .hsync(hs_s), .vsync(vs_s), .pixel_addr(addr_s), .pix_tick(pt_s),
    .frame_tick(ft_s), .clk_blink(bl_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Raster state as a function of clocks elapsed since the last reset edge.
  function automatic obs_t model(int t, int cd, int hd, int hfp, int hsw, int hbp,
                                 int vd, int vfp, int vsw, int vbp, int bf);
    int ht, vt, p, h, v, f, a;
    logic vld, hsy, vsy, pt, ft, bl;
    ht  = hd + hfp + hsw + hbp;
    vt  = vd + vfp + vsw + vbp;
    p   = t / cd;
    h   = p % ht;
    v   = (p / ht) % vt;
    f   = p / (ht * vt);
    vld = (h < hd) && (v < vd);
    hsy = !((h >= hd + hfp) && (h < hd + hfp + hsw));
    vsy = !((v >= vd + vfp) && (v < vd + vfp + vsw));
    a   = vld ? (h / 2) + (hd / 2) * (v / 2) : 0;
    pt  = (t > 0) && (t % cd == 0);
    ft  = pt && (p % (ht * vt) == 0);
    bl  = ((f / bf) % 2) == 1;
    return {10'(h), 10'(v), vld, hsy, vsy, 17'(a), pt, ft, bl};
  endfunction

  obs_t q_f[$];
  obs_t q_s[$];
  int   cyc = 0;
  int   t_f = 0, t_s = 0;
  bit   live_f = 0, live_s = 0;
  int   rst_cyc_f = 0;
  int   last_ft_s = 0, nft_s = 0, nft_total_s = 0;
  bit   vs_fall_ok = 0;
  int   vs_fall_cyc = 0;

  // Scoreboard producer: advance the model on each edge and queue the expectation.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        t_f = 0; live_f = 1; rst_cyc_f = cyc;
      end else if (live_f) begin
        t_f++;
      end
      if (live_f) q_f.push_back(model(t_f, 4, 640, 16, 96, 48, 480, 10, 2, 33, 30));
      if (!rst_s_n) begin
        t_s = 0; live_s = 1; last_ft_s = cyc; nft_s = 0; vs_fall_ok = 0;
      end else if (live_s) begin
        t_s++;
      end
      if (live_s) q_s.push_back(model(t_s, 2, 8, 1, 2, 1, 6, 1, 1, 1, 2));
    end
  end

  // Scoreboard consumer: compare the whole output bundle half a clock after the edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (q_f.size() > 0) begin
        e = q_f.pop_front();
        if (n_fail < 40)
          check("full_raster", 64'({h_f, v_f, valid_f, hs_f, vs_f, addr_f, pt_f, ft_f, bl_f}), 64'(e));
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        if (n_fail < 40)
          check("small_raster", 64'({h_s, v_s, valid_s, hs_s, vs_s, addr_s, pt_s, ft_s, bl_s}), 64'(e));
      end
    end
  end

  bit   line_done = 0, hs_fell = 0, hs_done = 0, vf_done = 0, a57_done = 0;
  bit   sa1 = 0, sa2 = 0, sa3 = 0;
  int   npix = 0, hs_fall_cyc = 0;
  int   vb_seen = 0, vb_viol = 0;
  logic [9:0] prev_h = '0, prev_v = '0;
  logic prev_hs = 1'b0, prev_valid = 1'b0, prev_vs_s = 1'b0;

  // Event monitors for the line period, sync windows, strobes and address corners.
  initial begin
    forever begin
      @(negedge clk);
      if (!line_done && pt_f === 1'b1) npix++;
      if (!line_done && prev_v == 10'd0 && v_f == 10'd1) begin
        check("line_period", 64'(cyc - rst_cyc_f), 64'(3200));
        check("h_before_wrap", 64'(prev_h), 64'(799));
        check("h_after_wrap", 64'(h_f), 64'(0));
        check("pix_ticks_line", 64'(npix), 64'(800));
        line_done = 1;
      end
      if (!vf_done && prev_valid === 1'b1 && valid_f === 1'b0) begin
        check("valid_fall_h", 64'(h_f), 64'(640));
        vf_done = 1;
      end
      if (!hs_done && v_f == 10'd10 && prev_hs === 1'b1 && hs_f === 1'b0) begin
        check("hsync_fall_h", 64'(h_f), 64'(656));
        hs_fell = 1; hs_fall_cyc = cyc;
      end
      if (!hs_done && hs_fell && prev_hs === 1'b0 && hs_f === 1'b1) begin
        check("hsync_rise_h", 64'(h_f), 64'(752));
        check("hsync_low_clks", 64'(cyc - hs_fall_cyc), 64'(384));
        hs_done = 1;
      end
      if (!a57_done && h_f == 10'd5 && v_f == 10'd7) begin
        check("addr_5_7", 64'(addr_f), 64'(962));
        a57_done = 1;
      end
      prev_h = h_f; prev_v = v_f; prev_hs = hs_f; prev_valid = valid_f;

      if (ft_s === 1'b1) begin
        check("frame_period", 64'(cyc - last_ft_s), 64'(216));
        check("frame_tick_pos", 64'({h_s, v_s}), 64'(0));
        last_ft_s = cyc; nft_s++; nft_total_s++;
        if (nft_s % 2 == 0) check("blink_at_ft", 64'(bl_s), 64'((nft_s / 2) % 2));
      end
      if (prev_vs_s === 1'b1 && vs_s === 1'b0) begin
        check("vsync_fall_pos", 64'({v_s, h_s}), 64'({10'd7, 10'd0}));
        vs_fall_ok = 1; vs_fall_cyc = cyc;
      end
      if (vs_fall_ok && prev_vs_s === 1'b0 && vs_s === 1'b1) begin
        check("vsync_rise_pos", 64'({v_s, h_s}), 64'({10'd8, 10'd0}));
        check("vsync_low_clks", 64'(cyc - vs_fall_cyc), 64'(24));
        vs_fall_ok = 0;
      end
      prev_vs_s = vs_s;
      if (v_s >= 10'd6 && v_s <= 10'd8) begin
        vb_seen++;
        if (valid_s !== 1'b0) vb_viol++;
      end
      if (!sa1 && h_s == 10'd7 && v_s == 10'd5) begin
        check("small_addr_last", 64'(addr_s), 64'(11)); sa1 = 1;
      end
      if (!sa2 && h_s == 10'd8 && v_s == 10'd0) begin
        check("small_addr_hblank", 64'(addr_s), 64'(0)); sa2 = 1;
      end
      if (!sa3 && h_s == 10'd0 && v_s == 10'd6) begin
        check("small_addr_vblank", 64'(addr_s), 64'(0)); sa3 = 1;
      end
    end
  end

  bit small_done = 0;

  // Reduced instance: after six frames, reset it for one clock inside the vsync pulse.
  initial begin
    bit found;
    repeat (4) @(negedge clk);
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (nft_s >= 6 && v_s == 10'd7 && vs_s === 1'b0) found = 1;
    end
    check("small_vsync_reached", 64'(found), 64'(1));
    check("small_blink_before_rst", 64'(bl_s), 64'(1));
    rst_s_n = 1'b0;
    @(negedge clk);
    check("small_rst_pos", 64'({h_s, v_s}), 64'(0));
    check("small_rst_syncs", 64'({valid_s, hs_s, vs_s}), 64'(3'b111));
    check("small_rst_strobes", 64'({pt_s, ft_s, bl_s}), 64'(0));
    rst_s_n = 1'b1;
    small_done = 1;
  end

  // Main sequence: reset, free-run the full instance, then a mid-line reset inside hsync.
  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check("reset_pos", 64'({h_f, v_f, addr_f}), 64'(0));
    check("reset_flags", 64'({valid_f, hs_f, vs_f, pt_f, ft_f, bl_f}), 64'(6'b111000));
    rst_n = 1'b1;
    rst_s_n = 1'b1;
    found = 0;
    for (int i = 0; i < 45000 && !found; i++) begin
      @(negedge clk);
      if (v_f == 10'd11 && hs_f === 1'b0) found = 1;
    end
    check("full_hsync_reached", 64'(found), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("midline_rst_pos", 64'({h_f, v_f}), 64'(0));
    check("midline_rst_syncs", 64'({valid_f, hs_f, vs_f}), 64'(3'b111));
    rst_n = 1'b1;
    repeat (4000) @(negedge clk);
    for (int i = 0; i < 2000 && !small_done; i++) @(negedge clk);
    check("small_seq_done", 64'(small_done), 64'(1));
    check("line_checked", 64'(line_done), 64'(1));
    check("hsync_checked", 64'(hs_done), 64'(1));
    check("addr_5_7_seen", 64'(a57_done), 64'(1));
    check("small_frames_seen", 64'(nft_total_s >= 8), 64'(1));
    check("vblank_seen", 64'(vb_seen > 0), 64'(1));
    check("vblank_valid_low", 64'(vb_viol), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock. Produces the pixel counters, the display-valid flag, active-low sync pulses, a ROM pixel address for 320x240 images upscaled 2x, a frame strobe and a slow blink clock. It drives the pixel-composition stage and the image ROMs, and its `hsync`/`vsync` go straight to the board pins.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate).
- `H_DISP`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48. Horizontal visible, front porch, sync and back porch widths in pixels.
- `V_DISP`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 33. Vertical widths in lines.
- `BLINK_FRAMES`, 30: frames per `clk_blink` half-period.
- `clk`  in  1  system clock, 100 MHz. This is the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `h_cnt`  out  10  horizontal pixel index, 0..799.
- `v_cnt`  out  10  vertical line index, 0..524.
- `valid`  out  1  high when h_cnt < 640 and v_cnt < 480.
- `hsync`  out  1  active-low horizontal sync.
- `vsync`  out  1  active-low vertical sync.
- `pixel_addr`  out  17  (h_cnt>>1) + 320*(v_cnt>>1) when valid; 0 otherwise.
- `pix_tick`  out  1  one-clk pulse on each pixel advance.
- `frame_tick`  out  1  one-clk pulse when the raster returns to (0,0).
- `clk_blink`  out  1  square wave toggled every BLINK_FRAMES frames.

## Operation
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525. Both are computed from the parameters and are not separate parameters.
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pix_tick` is registered high in the cycle after `div` reaches CLK_DIV-1.
- Pixel counters change only on clock edges where `div == CLK_DIV-1`. Each (h,v) pair is therefore held for exactly CLK_DIV clocks.
- Horizontal wrap: h = 799 goes to 0, and v increments in the same edge.
- Vertical wrap: v = 524 goes to 0, but only when h also wraps.
- `hsync` is low for h in [656, 751]. `vsync` is low for v in [490, 491].
- `hsync`, `vsync` and `valid` are registers computed from the next counter values. They change on the same edge as `h_cnt`/`v_cnt`, with zero skew relative to the counters.
- `pixel_addr` is a combinational decode of the registered counters. Width: 319 + 320*239 = 76799, which fits in 17 bits. No modulo is needed.
- `frame_tick` is registered high for one clk on the edge where the counters become (0,0) from (799,524).
- Frame counter `fcnt`:
  - counts 0..BLINK_FRAMES-1, advancing on each `frame_tick` edge;
  - on wrap, `clk_blink` toggles.
  - Blink period = 2*BLINK_FRAMES frames = 1 s nominal.
- No handshake. Consumers sample every clk. Pixel data must be stable for the CLK_DIV-clock pixel window.

## Timing
- Reset values, taking effect on the first rising edge with rst_n = 0:
  - div = 0, h_cnt = 0, v_cnt = 0, valid = 1, hsync = 1, vsync = 1, pixel_addr = 0;
  - pix_tick = 0, frame_tick = 0, fcnt = 0, clk_blink = 0.
- Reset applied mid-line or mid-frame returns everything to the values above on the next edge. No partial sync pulse persists.
- First advance after reset release: if rst_n is high from edge E0, then h_cnt becomes 1 at edge E0+CLK_DIV-1 (div counts 0,1,2,3).
- Periods:
  - line = 800*CLK_DIV = 3200 clks;
  - frame = 525*3200 = 1,680,000 clks;
  - hsync pulse = 96*4 = 384 clks;
  - vsync pulse = 2*3200 = 6400 clks.
- `valid` falls on the edge where h_cnt becomes 640 and rises on the edge where h_cnt becomes 0 within v < 480.
- `valid` remains 0 for all h while v is in 480..524.
- Simultaneous H and V wrap: h, v, vsync, valid and frame_tick all update on the same edge.
- `clk_blink` toggles on the same edge that `frame_tick` is asserted for the BLINK_FRAMES-th frame.

## Test plan
- **Reset then free-run one line:** rst_n low 3 clks, then high.
  - Check the reset values.
  - h_cnt reaches 799 after 3200 clks and then wraps to 0 while v_cnt becomes 1.
  - pix_tick fires every 4 clks.
- **hsync window:** on line v = 10, hsync goes low on the edge where h_cnt becomes 656 and high where it becomes 752. Low for exactly 384 clks.
- **vsync/valid frame boundary:**
  - valid = 0 for the whole of line 480.
  - vsync is low from (h=0, v=490) to (h=0, v=492), i.e. 6400 clks.
  - frame_tick pulses exactly once at (799,524) to (0,0), 1,680,000 clks after the previous pulse.
- **pixel_addr:** at (h=5, v=7), pixel_addr = 2 + 320*3 = 962. At (639,479) it is 76799. At (640,0) and (0,480) it is 0.
- **Blink:** run 60 frames with BLINK_FRAMES = 30. clk_blink rises at the 30th frame_tick and falls at the 60th. Use a reduced-parameter instance (e.g. H 8/1/2/1, V 6/1/1/1, CLK_DIV 2, BLINK_FRAMES 2) to check that generics scale correctly.
- **Mid-frame reset:** assert rst_n = 0 for 1 clk while v_cnt = 491 and vsync is low. On the next edge, all outputs hold their reset values (vsync = 1, h_cnt = v_cnt = 0, fcnt and clk_blink = 0).
